// File: rtl/nn_pkg.sv
// Shared types and helpers for the nnt layer sequencer: state encoding,
// default widths and the ReLU used on hidden-layer results.
package nn_pkg;

  localparam int NN_ADDR_W = 16;
  localparam int NN_DATA_W = 32;
  localparam int NN_CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_ACT = 3'd1,
    S_RD_W   = 3'd2,
    S_MAC    = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5
  } seq_state_e;

  // Sign is taken from the MSB: negative accumulators clip to zero.
  function automatic logic [NN_DATA_W-1:0] relu(input logic [NN_DATA_W-1:0] x);
    return x[NN_DATA_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/nnt_layer_sequencer_if.sv
// Memory and MAC bus between the layer sequencer (master) and the nnt top (slave).
// Handshake: no backpressure. mem_req_o qualifies one access in the cycle it is high
// (write if mem_we_o, else read whose data appears on mem_rdata_i the next cycle);
// mac_valid_o qualifies mac_a_o/mac_b_o for exactly one accumulate at the next edge.
interface nnt_layer_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mac_valid_o;
  logic              mac_clr_o;
  logic [DATA_W-1:0] mac_a_o;
  logic [DATA_W-1:0] mac_b_o;
  logic [DATA_W-1:0] mac_acc_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mac_valid_o, mac_clr_o, mac_a_o, mac_b_o,
    input  mem_rdata_i, mac_acc_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mac_valid_o, mac_clr_o, mac_a_o, mac_b_o,
    output mem_rdata_i, mac_acc_i
  );
endinterface

// File: rtl/nnt_layer_sequencer_counters.sv
// Layer/neuron/input counters and weight pointer for the sequencer, with
// last-element flags derived from the latched layer sizes.
module nnt_seq_counters
  import nn_pkg::*;
#(
  parameter int ADDR_W      = NN_ADDR_W,
  parameter int LAYER_COUNT = 2,
  parameter int CNT_W       = NN_CNT_W,
  parameter int L_W         = $clog2(LAYER_COUNT + 1)
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic                               init_i,
  input  logic [ADDR_W-1:0]                  init_wptr_i,
  input  logic                               mac_step_i,
  input  logic                               wb_step_i,
  input  logic [LAYER_COUNT:0][CNT_W-1:0]    size_i,
  input  logic [LAYER_COUNT-1:0][ADDR_W-1:0] w_base_i,
  output logic [L_W-1:0]                     l_o,
  output logic [CNT_W-1:0]                   n_o,
  output logic [CNT_W-1:0]                   k_o,
  output logic [ADDR_W-1:0]                  w_ptr_o,
  output logic                               k_last_o,
  output logic                               n_last_o,
  output logic                               l_last_o
);
  logic [L_W-1:0]    l_q, l_d;
  logic [CNT_W-1:0]  n_q, n_d, k_q, k_d;
  logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [CNT_W-1:0]  size_cur, size_nxt;
  logic [ADDR_W-1:0] wbase_nxt;

  always_comb begin
    size_cur  = '0;
    size_nxt  = '0;
    wbase_nxt = '0;
    for (int i = 0; i <= LAYER_COUNT; i++) begin
      if (int'(l_q) == i)     size_cur = size_i[i];
      if (int'(l_q) + 1 == i) size_nxt = size_i[i];
    end
    for (int i = 0; i < LAYER_COUNT; i++) begin
      if (int'(l_q) + 1 == i) wbase_nxt = w_base_i[i];
    end
  end

  assign k_last_o = (k_q == size_cur - CNT_W'(1));
  assign n_last_o = (n_q == size_nxt - CNT_W'(1));
  assign l_last_o = (int'(l_q) == LAYER_COUNT - 1);

  // The weight pointer runs continuously through a layer's row-major matrix,
  // so it is only reloaded when moving on to the next layer.
  always_comb begin
    l_d     = l_q;
    n_d     = n_q;
    k_d     = k_q;
    w_ptr_d = w_ptr_q;
    if (init_i) begin
      l_d     = '0;
      n_d     = '0;
      k_d     = '0;
      w_ptr_d = init_wptr_i;
    end else if (mac_step_i) begin
      w_ptr_d = w_ptr_q + ADDR_W'(1);
      if (!k_last_o) k_d = k_q + CNT_W'(1);
    end else if (wb_step_i) begin
      k_d = '0;
      if (!n_last_o) begin
        n_d = n_q + CNT_W'(1);
      end else if (!l_last_o) begin
        l_d     = l_q + L_W'(1);
        n_d     = '0;
        w_ptr_d = wbase_nxt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      l_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      w_ptr_q <= '0;
    end else begin
      l_q     <= l_d;
      n_q     <= n_d;
      k_q     <= k_d;
      w_ptr_q <= w_ptr_d;
    end
  end

  assign l_o     = l_q;
  assign n_o     = n_q;
  assign k_o     = k_q;
  assign w_ptr_o = w_ptr_q;

endmodule

// File: rtl/nnt_layer_sequencer.sv
// Control FSM running a fully-connected network over one shared memory and one
// external MAC: fetch activation, fetch weight, accumulate, write back each neuron.
module nnt_layer_sequencer
  import nn_pkg::*;
#(
  parameter int ADDR_W      = NN_ADDR_W,
  parameter int DATA_W      = NN_DATA_W,
  parameter int LAYER_COUNT = 2,
  parameter int CNT_W       = NN_CNT_W
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic                               start_i,
  input  logic [LAYER_COUNT:0][CNT_W-1:0]    size_i,
  input  logic [LAYER_COUNT:0][ADDR_W-1:0]   act_base_i,
  input  logic [LAYER_COUNT-1:0][ADDR_W-1:0] w_base_i,
  nnt_layer_sequencer_if.master              bus,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o,
  output seq_state_e                         dbg_state_o
);
  localparam int L_W = $clog2(LAYER_COUNT + 1);

  seq_state_e                         state_q, state_d;
  logic [LAYER_COUNT:0][CNT_W-1:0]    size_q;
  logic [LAYER_COUNT:0][ADDR_W-1:0]   act_base_q;
  logic [LAYER_COUNT-1:0][ADDR_W-1:0] w_base_q;
  logic [DATA_W-1:0]                  act_reg_q;
  logic                               err_q;
  logic                               cfg_bad, accept;
  logic [L_W-1:0]                     l_cnt;
  logic [CNT_W-1:0]                   n_cnt, k_cnt;
  logic [ADDR_W-1:0]                  w_ptr, act_cur, act_nxt;
  logic                               k_last, n_last, l_last;

  always_comb begin
    cfg_bad = 1'b0;
    for (int i = 0; i <= LAYER_COUNT; i++) begin
      if (size_i[i] == '0) cfg_bad = 1'b1;
    end
  end

  assign accept = (state_q == S_IDLE) && start_i && !cfg_bad;

  // w_base_i[0] is taken straight from the port: it is latched on the same edge.
  nnt_seq_counters #(
    .ADDR_W(ADDR_W), .LAYER_COUNT(LAYER_COUNT), .CNT_W(CNT_W), .L_W(L_W)
  ) u_counters (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .init_i      (accept),
    .init_wptr_i (w_base_i[0]),
    .mac_step_i  (state_q == S_MAC),
    .wb_step_i   (state_q == S_WB),
    .size_i      (size_q),
    .w_base_i    (w_base_q),
    .l_o         (l_cnt),
    .n_o         (n_cnt),
    .k_o         (k_cnt),
    .w_ptr_o     (w_ptr),
    .k_last_o    (k_last),
    .n_last_o    (n_last),
    .l_last_o    (l_last)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      size_q     <= '0;
      act_base_q <= '0;
      w_base_q   <= '0;
      act_reg_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_i) err_q <= cfg_bad;
      if (accept) begin
        size_q     <= size_i;
        act_base_q <= act_base_i;
        w_base_q   <= w_base_i;
      end
      if (state_q == S_RD_W) act_reg_q <= bus.mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_RD_ACT;
      S_RD_ACT: state_d = S_RD_W;
      S_RD_W:   state_d = S_MAC;
      S_MAC:    state_d = k_last ? S_WB : S_RD_ACT;
      S_WB:     state_d = (n_last && l_last) ? S_DONE : S_RD_ACT;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    act_cur = '0;
    act_nxt = '0;
    for (int i = 0; i <= LAYER_COUNT; i++) begin
      if (int'(l_cnt) == i)     act_cur = act_base_q[i];
      if (int'(l_cnt) + 1 == i) act_nxt = act_base_q[i];
    end
  end

  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mac_valid_o = 1'b0;
    bus.mac_clr_o   = 1'b0;
    bus.mac_a_o     = '0;
    bus.mac_b_o     = '0;
    done_o          = 1'b0;
    unique case (state_q)
      S_RD_ACT: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = act_cur + ADDR_W'(k_cnt);
      end
      S_RD_W: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = w_ptr;
      end
      S_MAC: begin
        bus.mac_valid_o = 1'b1;
        bus.mac_clr_o   = (k_cnt == '0);
        bus.mac_a_o     = act_reg_q;
        bus.mac_b_o     = bus.mem_rdata_i;
      end
      S_WB: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = act_nxt + ADDR_W'(n_cnt);
        bus.mem_wdata_o = l_last ? bus.mac_acc_i : relu(bus.mac_acc_i);
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule
